// File: rtl/toggle_seq.sv
// rtl/toggle_seq.sv - issues counted, gap-spaced T pulses to a downstream toggle flip-flop
// and checks its Q feedback after every pulse.
module toggle_seq #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic             Clk,
  input  logic             t_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  output logic             T,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic             exp_q;
  logic             chk_pend;

  always_ff @(posedge Clk) begin
    if (t_rst) begin
      state     <= IDLE;
      remaining <= '0;
      gap_lat   <= '0;
      gap_cnt   <= '0;
      exp_q     <= 1'b0;
      err       <= 1'b0;
      chk_pend  <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Q has settled one cycle after the pulse that toggled it.
      chk_pend <= (state == PULSE);
      if (chk_pend && (q_fb != exp_q)) err <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            remaining <= cmd_count;
            gap_lat   <= cmd_gap;
            exp_q     <= q_fb;
            err       <= 1'b0;
          end
        end
        PULSE: begin
          if (remaining != '0) remaining <= remaining - 1'b1;
          exp_q   <= ~exp_q;
          gap_cnt <= gap_lat;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    T         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = (cmd_count == '0) ? DONE : PULSE;
      end
      PULSE: begin
        T = !t_rst;
        // The last pulse goes straight to DONE with no trailing gap.
        if (remaining <= 1) state_nxt = DONE;
        else if (gap_lat != '0) state_nxt = GAP;
        else state_nxt = PULSE;
      end
      GAP: begin
        if (gap_cnt <= 1) state_nxt = PULSE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
